// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: operand/store/CSR forwarding selects, load-use interlock,
// trap/CSR/standby/redirect/post-trap flush-stall generation and a saturating
// count of stall cycles. Selects and pipeline controls are combinational;
// only the FSM state, the load-use counter and the stall counter are registers.
module hazard_ctrl_unit #(
  parameter int NUM_SRC         = 2,
  parameter int FWD_STAGES      = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int STORE_SRC       = 1,
  parameter int CSR_ADDR_W      = 12,
  parameter int SEL_W           = 3
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             trap_done,
  input  logic                             csr_ready,
  input  logic                             standby_mode,
  input  logic                             pth_done_flush,
  input  logic                             redirect,
  input  logic [5*NUM_SRC-1:0]             id_rs,
  input  logic [NUM_SRC-1:0]               id_rs_used,
  input  logic [5*NUM_SRC-1:0]             ex_rs,
  input  logic [NUM_SRC-1:0]               ex_rs_used,
  input  logic [4:0]                       ex_rd,
  input  logic                             ex_reg_we,
  input  logic                             ex_is_load,
  input  logic                             ex_is_store,
  input  logic [CSR_ADDR_W-1:0]            ex_csr_addr,
  input  logic [5*FWD_STAGES-1:0]          fwd_rd,
  input  logic [FWD_STAGES-1:0]            fwd_reg_we,
  input  logic [FWD_STAGES-1:0]            fwd_csr_we,
  input  logic [CSR_ADDR_W*FWD_STAGES-1:0] fwd_csr_addr,
  output logic [SEL_W*NUM_SRC-1:0]         alu_fwd_sel,
  output logic [SEL_W-1:0]                 store_fwd_sel,
  output logic [SEL_W-1:0]                 csr_fwd_sel,
  output logic                             pc_stall,
  output logic                             IF_ID_stall,
  output logic                             ID_EX_stall,
  output logic                             EX_MEM_stall,
  output logic                             MEM_WB_stall,
  output logic                             IF_ID_flush,
  output logic                             ID_EX_flush,
  output logic                             EX_MEM_flush,
  output logic                             MEM_WB_flush,
  output logic [31:0]                      stall_cycles
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_STALL  = 2'd1,
    SYS_STALL = 2'd2
  } state_t;

  // Remaining LU_STALL cycles after the first interlock cycle (at most 2).
  localparam logic [1:0] LU_INIT = 2'((LOAD_USE_CYCLES > 1) ? (LOAD_USE_CYCLES - 2) : 0);

  state_t      state_r, state_nxt_s;
  state_t      ret_state_r, ret_state_nxt_s;
  state_t      eff_state_s;
  logic [1:0]  lu_cnt_r, lu_cnt_nxt_s;
  logic [SEL_W*NUM_SRC-1:0] alu_sel_s;
  logic        lu_hit_s;
  logic        sys_busy_s;

  // Per-source operand forwarding: iterate oldest-to-youngest so the youngest match wins.
  always_comb begin
    alu_sel_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        alu_sel_s[SEL_W*i +: SEL_W] =
          (fwd_reg_we[k] && (fwd_rd[5*k +: 5] != 5'd0) &&
           (fwd_rd[5*k +: 5] == ex_rs[5*i +: 5]) && ex_rs_used[i])
          ? SEL_W'(k + 1) : alu_sel_s[SEL_W*i +: SEL_W];
      end
    end
  end

  // Store data takes its select from the store-data source; that ALU lane is then parked on the register file.
  always_comb begin
    alu_fwd_sel   = alu_sel_s;
    store_fwd_sel = {SEL_W{1'b0}};
    if (ex_is_store) begin
      alu_fwd_sel[SEL_W*STORE_SRC +: SEL_W] = {SEL_W{1'b0}};
      store_fwd_sel = alu_sel_s[SEL_W*STORE_SRC +: SEL_W];
    end else begin
      store_fwd_sel = {SEL_W{1'b0}};
    end
  end

  // CSR read forwarding: youngest producer writing the same CSR address wins (no zero exclusion).
  always_comb begin
    csr_fwd_sel = {SEL_W{1'b0}};
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      csr_fwd_sel = (fwd_csr_we[k] && (fwd_csr_addr[CSR_ADDR_W*k +: CSR_ADDR_W] == ex_csr_addr))
                    ? SEL_W'(k + 1) : csr_fwd_sel;
    end
  end

  // Load-use detection: EX load writing a nonzero register that an ID source reads.
  always_comb begin
    lu_hit_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lu_hit_s = lu_hit_s | (id_rs_used[i] && (id_rs[5*i +: 5] == ex_rd));
    end
    lu_hit_s = lu_hit_s && ex_is_load && ex_reg_we && (ex_rd != 5'd0);
  end

  assign sys_busy_s  = !trap_done || !csr_ready;
  // While frozen in SYS_STALL the saved state decides what happens once the freeze lifts.
  assign eff_state_s = (state_r == SYS_STALL) ? ret_state_r : state_r;

  // Prioritised stall/flush generation and next-state logic.
  always_comb begin
    pc_stall        = 1'b0;
    IF_ID_stall     = 1'b0;
    ID_EX_stall     = 1'b0;
    EX_MEM_stall    = 1'b0;
    MEM_WB_stall    = 1'b0;
    IF_ID_flush     = 1'b0;
    ID_EX_flush     = 1'b0;
    EX_MEM_flush    = 1'b0;
    MEM_WB_flush    = 1'b0;
    state_nxt_s     = eff_state_s;
    ret_state_nxt_s = ret_state_r;
    lu_cnt_nxt_s    = lu_cnt_r;
    if (!reset_n) begin
      state_nxt_s     = RUN;
      ret_state_nxt_s = RUN;
      lu_cnt_nxt_s    = 2'd0;
    end else if (pth_done_flush) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
      MEM_WB_flush = 1'b1;
      state_nxt_s  = RUN;
      lu_cnt_nxt_s = 2'd0;
    end else if (sys_busy_s) begin
      pc_stall        = 1'b1;
      IF_ID_stall     = 1'b1;
      ID_EX_stall     = 1'b1;
      EX_MEM_stall    = 1'b1;
      MEM_WB_stall    = 1'b1;
      state_nxt_s     = SYS_STALL;
      ret_state_nxt_s = eff_state_s;
    end else if (standby_mode) begin
      pc_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_EX_stall = 1'b1;
      state_nxt_s = eff_state_s;
    end else if (redirect) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      state_nxt_s  = RUN;
      lu_cnt_nxt_s = 2'd0;
    end else begin
      case (eff_state_s)
        RUN: begin
          if (lu_hit_s) begin
            pc_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_nxt_s  = LU_STALL;
              lu_cnt_nxt_s = LU_INIT;
            end else begin
              state_nxt_s  = RUN;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        LU_STALL: begin
          pc_stall    = 1'b1;
          IF_ID_stall = 1'b1;
          ID_EX_flush = 1'b1;
          if (lu_cnt_r == 2'd0) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s  = LU_STALL;
            lu_cnt_nxt_s = lu_cnt_r - 2'd1;
          end
        end
        default: begin
          state_nxt_s  = RUN;
          lu_cnt_nxt_s = 2'd0;
        end
      endcase
    end
  end

  // FSM state, saved return state and load-use counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= RUN;
      ret_state_r <= RUN;
      lu_cnt_r    <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      ret_state_r <= ret_state_nxt_s;
      lu_cnt_r    <= lu_cnt_nxt_s;
    end
  end

  // Saturating performance counter of cycles in which the front or back of the pipe is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= 32'd0;
    end else if ((pc_stall || MEM_WB_stall) && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the core's hazard unit. Generalises forwarding to NUM_SRC operands across FWD_STAGES writeback stages, and adds load-use interlock with a multi-cycle stall counter. Also provides per-stage flush/stall generation for trap, standby, redirect and post-trap-handler flush, plus a saturating hazard-stall performance counter. Sits beside the ID/EX/MEM/WB pipeline registers and drives the forward unit and the pipeline register enables.

Parameters:
NUM_SRC, 2, EX/ID source operands checked (2..3)
FWD_STAGES, 2, forwarding producer stages, index 0 = youngest (MEM), 1 = WB, ... (1..4)
LOAD_USE_CYCLES, 1, stall cycles inserted per load-use hazard (1..4)
STORE_SRC, 1, source index carrying store data
CSR_ADDR_W, 12, CSR address width
SEL_W, 3, forward-select width, must satisfy 2^SEL_W > FWD_STAGES

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
trap_done  in  1  0 = trap sequencer busy
csr_ready  in  1  0 = CSR file busy
standby_mode  in  1  ID-phase exception standby
pth_done_flush  in  1  post-trap-handler full flush
redirect  in  1  branch_prediction_miss OR EX_jump
id_rs  in  5*NUM_SRC  ID source registers, packed
id_rs_used  in  NUM_SRC  ID source valid mask
ex_rs  in  5*NUM_SRC  EX source registers
ex_rs_used  in  NUM_SRC  EX source valid mask
ex_rd  in  5  EX destination
ex_reg_we  in  1  EX writes register
ex_is_load  in  1  EX is a load
ex_is_store  in  1  EX is a store
ex_csr_addr  in  CSR_ADDR_W  EX CSR address
fwd_rd  in  5*FWD_STAGES  producer destinations
fwd_reg_we  in  FWD_STAGES  producer register write enables
fwd_csr_we  in  FWD_STAGES  producer CSR write enables
fwd_csr_addr  in  CSR_ADDR_W*FWD_STAGES  producer CSR addresses
alu_fwd_sel  out  SEL_W*NUM_SRC  per-source select: 0 = register file, k+1 = stage k
store_fwd_sel  out  SEL_W  store-data select, same encoding
csr_fwd_sel  out  SEL_W  CSR-read select, same encoding
pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall  out  1 each
IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each
stall_cycles  out  32  saturating count of stall-asserted cycles

Behaviour:
- Forwarding is combinational.
  - Stage k matches source i when fwd_reg_we[k] && fwd_rd[k]!=0 && fwd_rd[k]==ex_rs[i] && ex_rs_used[i].
  - The lowest matching k wins and the select is k+1. No match gives 0.
- When ex_is_store, alu_fwd_sel[STORE_SRC]=0 and its computed value goes to store_fwd_sel. Otherwise store_fwd_sel=0.
- CSR forwarding: csr_fwd_sel uses the lowest k with fwd_csr_we[k] && fwd_csr_addr[k]==ex_csr_addr. There is no x0-style exclusion.
- Load-use hazard (lu_hit) is ex_is_load && ex_reg_we && ex_rd!=0 && any i with id_rs_used[i] && id_rs[i]==ex_rd.
- FSM states:
  - RUN, the reset state.
  - LU_STALL, which holds counter lu_cnt.
  - SYS_STALL, entered while !trap_done || !csr_ready. It records the return state and freezes lu_cnt.
- Combinational priority per cycle, highest first:
  1. pth_done_flush: all four flushes=1, no stalls. FSM goes to RUN and lu_cnt clears.
  2. !trap_done || !csr_ready: all five stalls=1. FSM holds via SYS_STALL and resumes the saved state afterwards.
  3. standby_mode: pc_stall, IF_ID_stall and ID_EX_stall=1. EX_MEM and MEM_WB run.
  4. redirect (only when trap_done): IF_ID_flush and ID_EX_flush=1. Any pending LU_STALL is cancelled and the FSM goes to RUN.
  5. Load-use: triggered by lu_hit in RUN, or by state LU_STALL. Outputs are pc_stall=1, IF_ID_stall=1 and ID_EX_flush=1 (bubble).
     - From RUN with LOAD_USE_CYCLES>1: go to LU_STALL with lu_cnt=LOAD_USE_CYCLES-2.
     - In LU_STALL: decrement each cycle and return to RUN after the cycle with lu_cnt==0.
     - With LOAD_USE_CYCLES=1 the FSM stays in RUN.
- Redirect and pth_done_flush both override an active stall. A flush output and a stall output of the same register are never both 1.
- stall_cycles increments on any cycle with pc_stall || MEM_WB_stall and saturates at 0xFFFFFFFF.
- Reset: asserting reset_n low mid-operation immediately returns the FSM to RUN and clears lu_cnt and stall_cycles. All outputs are then combinationally 0 except the forward selects, which follow their inputs.

Test Plan:
- ex_rs={x5,x6}, fwd_rd={x5,x5} with both we=1 -> alu_fwd_sel[0]=1 (MEM wins), alu_fwd_sel[1]=0. Same case with rd=x0 -> 0.
- ex_is_store, ex_rs[1]=x7, fwd_rd[1]=x7 -> alu_fwd_sel[1]=0, store_fwd_sel=2.
- LOAD_USE_CYCLES=3, EX load x9, ID rs1=x9 -> pc/IF_ID stall and ID_EX_flush for exactly 3 cycles, then RUN. stall_cycles=3.
- In LU_STALL cycle 2, trap_done=0 for 4 cycles -> full stall for 4 cycles. One LU stall cycle remains afterwards. stall_cycles increments 5 more.
- redirect during LU_STALL -> IF_ID_flush=ID_EX_flush=1 that cycle, no pc_stall, FSM=RUN next cycle.
- pth_done_flush with standby_mode=1 and redirect=1 -> all four flushes=1, all stalls=0. Drop reset_n mid-stall -> all stalls/flushes 0 immediately.
